// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync header, optionally reads a length field,
// shifts in the payload and an optional even-parity bit, then flags the frame good or bad.
module serial_frame_rx #(
  parameter int               HDR_W   = 4,
  parameter logic [HDR_W-1:0] HDR_PAT = 4'b1011,
  parameter int               VAR_LEN = 0,
  parameter int               FIX_LEN = 8,
  parameter int               LEN_W   = 4,
  parameter int               DATA_W  = 16,
  parameter int               PAR_EN  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic                          ser_in,
  output logic                          ser_out,
  output logic                          ser_out_valid,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_valid,
  output logic                          frame_err,
  output logic [$clog2(DATA_W+1)-1:0]   bit_cnt,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int CNT_W = $clog2(DATA_W+1);
  localparam int LC_W  = (LEN_W > 1) ? $clog2(LEN_W+1) : 1;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q;
  logic [HDR_W-1:0]  hist_q;
  logic [LEN_W-1:0]  len_q;
  logic [LC_W-1:0]   len_cnt_q;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic              par_q;
  logic              data_valid_q;
  logic              frame_err_q;

  logic [HDR_W-1:0]  hist_d;
  logic [LEN_W-1:0]  len_d;
  logic [DATA_W-1:0] data_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              len_bad;

  // Shifted views of the registers as they would look after taking ser_in.
  assign hist_d  = HDR_W'({hist_q, ser_in});
  assign len_d   = LEN_W'({len_q, ser_in});
  assign data_d  = DATA_W'({data_q, ser_in});
  assign cnt_inc = bit_cnt_q + 1'b1;
  assign len_bad = (len_d == '0) || (int'(len_d) > DATA_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= HUNT;
      hist_q       <= '0;
      len_q        <= '0;
      len_cnt_q    <= '0;
      target_q     <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        HUNT: if (clk_en) begin
          hist_q <= hist_d;
          if (hist_d == HDR_PAT) begin
            if (VAR_LEN != 0) begin
              state_q   <= LEN;
              len_cnt_q <= '0;
            end else begin
              state_q   <= PAYLOAD;
              target_q  <= CNT_W'(FIX_LEN);
              data_q    <= '0;
              bit_cnt_q <= '0;
              par_q     <= 1'b0;
            end
          end
        end
        LEN: if (clk_en) begin
          len_q     <= len_d;
          len_cnt_q <= len_cnt_q + 1'b1;
          if (len_cnt_q == LC_W'(LEN_W-1)) begin
            if (len_bad) begin
              state_q     <= DONE;
              frame_err_q <= 1'b1;
            end else begin
              state_q   <= PAYLOAD;
              target_q  <= CNT_W'(len_d);
              data_q    <= '0;
              bit_cnt_q <= '0;
              par_q     <= 1'b0;
            end
          end
        end
        PAYLOAD: if (clk_en) begin
          data_q    <= data_d;
          bit_cnt_q <= cnt_inc;
          par_q     <= par_q ^ ser_in;
          if (cnt_inc == target_q) begin
            if (PAR_EN != 0) begin
              state_q <= PARITY;
            end else begin
              state_q      <= DONE;
              data_valid_q <= 1'b1;
            end
          end
        end
        PARITY: if (clk_en) begin
          state_q      <= DONE;
          data_valid_q <= ~(par_q ^ ser_in);
          frame_err_q  <= par_q ^ ser_in;
        end
        // DONE ignores clk_en so the result pulse is always exactly one cycle.
        DONE: begin
          state_q   <= HUNT;
          hist_q    <= '0;
          bit_cnt_q <= '0;
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign ser_out_valid = (state_q == PAYLOAD);
  assign ser_out       = (state_q == PAYLOAD) ? ser_in : 1'b0;
  assign data_out      = data_q;
  assign data_valid    = data_valid_q;
  assign frame_err     = frame_err_q;
  assign bit_cnt       = bit_cnt_q;
  assign busy          = (state_q != HUNT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a fixed-length instance and a length-field instance
// share clock and reset; frame results are checked by a queue-based monitor.
module tb_serial_frame_rx;

  logic        clk;
  logic        rst;
  logic        en0, ser0, en1, ser1;
  logic        sout0, sov0, dv0, fe0, busy0;
  logic        sout1, sov1, dv1, fe1, busy1;
  logic [15:0] dout0, dout1;
  logic [4:0]  cnt0, cnt1;
  logic [2:0]  st0, st1;

  // Expected frame result: {frame_err, data_out, bit_cnt}
  logic [21:0] exp0_q[$];
  logic [21:0] exp1_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;

  serial_frame_rx dut0 (
    .clk(clk), .rst(rst), .clk_en(en0), .ser_in(ser0),
    .ser_out(sout0), .ser_out_valid(sov0), .data_out(dout0),
    .data_valid(dv0), .frame_err(fe0), .bit_cnt(cnt0), .busy(busy0),
    .dbg_state(st0)
  );

  serial_frame_rx #(.VAR_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(en1), .ser_in(ser1),
    .ser_out(sout1), .ser_out_valid(sov1), .data_out(dout1),
    .data_valid(dv1), .frame_err(fe1), .bit_cnt(cnt1), .busy(busy1),
    .dbg_state(st1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops an expected frame whenever a DUT reports a result pulse.
  always @(negedge clk) begin
    check("excl0", 32'(dv0 & fe0), 32'd0);
    check("excl1", 32'(dv1 & fe1), 32'd0);
    if (dv0 || fe0) begin
      if (exp0_q.size() == 0) check("unexpected_pulse0", 32'(1), 32'(0));
      else check("frame0", 32'({fe0, dout0, cnt0}), 32'(exp0_q.pop_front()));
    end
    if (dv1 || fe1) begin
      if (exp1_q.size() == 0) check("unexpected_pulse1", 32'(1), 32'(0));
      else check("frame1", 32'({fe1, dout1, cnt1}), 32'(exp1_q.pop_front()));
    end
    if (sov0) check("ser_out_track", 32'(sout0), 32'(ser0));
    else      check("ser_out_idle", 32'(sout0), 32'd0);
    if (en0 && sov0) strobes++;
  end

  // Driver tasks
  task automatic send_bit(input int d, input logic b, input int gap);
    if (d == 0) begin ser0 = b; en0 = 1'b1; end
    else        begin ser1 = b; en1 = 1'b1; end
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input logic [31:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(d, bits[i], gap);
  endtask

  initial begin
    rst = 1'b0; en0 = 1'b1; ser0 = 1'b1; en1 = 1'b1; ser1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(dout0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_state", 32'(st0), 32'd0);
    check("rst_dv", 32'(dv0), 32'd0);
    check("rst_fe", 32'(fe0), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    en0 = 1'b0; en1 = 1'b0; ser0 = 1'b0; ser1 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Good frame, continuous strobe: payload 0xA5 has four ones, parity 0
    exp0_q.push_back({1'b0, 16'h00A5, 5'd8});
    send(0, 32'b1011, 4, 0);
    check("hdr_cnt0", 32'(cnt0), 32'd0);
    send(0, 32'hA5, 8, 0);
    check("cnt_in_parity", 32'(cnt0), 32'd8);
    send(0, 32'd0, 1, 0);
    check("dv_after_parity", 32'(dv0), 32'd1);
    check("done_cnt", 32'(cnt0), 32'd8);
    @(posedge clk); #1;
    check("dv_one_cycle", 32'(dv0), 32'd0);
    check("busy_after_a", 32'(busy0), 32'd0);
    check("cnt_hunt", 32'(cnt0), 32'd0);
    check("data_hold", 32'(dout0), 32'h00A5);

    // Same frame with wrong parity
    exp0_q.push_back({1'b1, 16'h00A5, 5'd8});
    send(0, 32'b1011, 4, 0);
    send(0, 32'hA5, 8, 0);
    send(0, 32'd1, 1, 0);
    check("fe_after_parity", 32'(fe0), 32'd1);
    check("dv_on_error", 32'(dv0), 32'd0);
    @(posedge clk); #1;
    check("busy_after_err", 32'(busy0), 32'd0);

    // Strobe every 4th cycle
    strobes = 0;
    exp0_q.push_back({1'b0, 16'h00A5, 5'd8});
    send(0, 32'b1011, 4, 3);
    send(0, 32'hA5, 8, 3);
    check("strobes_8", 32'(strobes), 32'd8);
    send(0, 32'd0, 1, 0);
    check("dv_slow", 32'(dv0), 32'd1);
    @(posedge clk); #1;

    // Overlap in HUNT: 1101 is no header, the following 1 completes 1011
    exp0_q.push_back({1'b0, 16'h00FF, 5'd8});
    send(0, 32'b1101, 4, 0);
    check("no_hdr_1101", 32'(busy0), 32'd0);
    send(0, 32'b1, 1, 0);
    check("overlap_hdr", 32'(busy0), 32'd1);
    send(0, 32'hFF, 8, 0);
    send(0, 32'd0, 1, 0);
    @(posedge clk); #1;

    // Stream 1011011: header ends at bit 4, bits 5..7 are payload
    exp0_q.push_back({1'b0, 16'h0060, 5'd8});
    send(0, 32'b1011, 4, 0);
    check("payload_at_5", 32'(sov0), 32'd1);
    send(0, 32'b011, 3, 0);
    check("partial_cnt", 32'(cnt0), 32'd3);
    check("partial_data", 32'(dout0), 32'h0003);
    send(0, 32'b00000, 5, 0);
    send(0, 32'd0, 1, 0);
    @(posedge clk); #1;

    // Reset mid-payload: no pulse, everything back to zero
    send(0, 32'b1011, 4, 0);
    send(0, 32'b101, 3, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_data", 32'(dout0), 32'd0);
    check("midrst_cnt", 32'(cnt0), 32'd0);
    check("midrst_sov", 32'(sov0), 32'd0);
    check("midrst_pulse", 32'({dv0, fe0}), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    // Length-field instance: zero length is rejected right after the field
    exp1_q.push_back({1'b1, 16'h0000, 5'd0});
    send(1, 32'b1011, 4, 0);
    send(1, 32'b000, 3, 0);
    check("len_cnt_zero", 32'(cnt1), 32'd0);
    send(1, 32'b0, 1, 0);
    check("len0_err", 32'(fe1), 32'd1);
    @(posedge clk); #1;

    // Length 3, payload 101, parity 0
    exp1_q.push_back({1'b0, 16'h0005, 5'd3});
    send(1, 32'b1011, 4, 0);
    send(1, 32'b0011, 4, 0);
    send(1, 32'b101, 3, 0);
    send(1, 32'd0, 1, 0);
    check("len3_dv", 32'(dv1), 32'd1);
    @(posedge clk); #1;

    // Length 1, payload 1, parity 1
    exp1_q.push_back({1'b0, 16'h0001, 5'd1});
    send(1, 32'b1011, 4, 0);
    send(1, 32'b0001, 4, 0);
    send(1, 32'b1, 1, 0);
    send(1, 32'd1, 1, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 20 && (exp0_q.size() != 0 || exp1_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    check("pending0", 32'(exp0_q.size()), 32'd0);
    check("pending1", 32'(exp1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
